// File: rtl/id_decode_queue_if.sv
// Handshake and decoded-field bundle between fetch, the decode queue and execute.
// The slave modport is the decode queue; the master modport drives it and consumes the fields.
interface id_decode_queue_if #(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int MEMOP_W = 4,
  parameter int DEPTH   = 2
);
  localparam int OPND_W = INSTR_W - OPC_W - MEMOP_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                in_valid;
  logic                in_ready;
  logic [INSTR_W-1:0]  instr;
  logic                out_valid;
  logic                out_ready;
  logic [OPC_W-1:0]    op_code;
  logic [MEMOP_W-1:0]  mem_op;
  logic [OPND_W-1:0]   operand;
  logic [OPND_W/2-1:0] left_operand;
  logic [OPND_W/2-1:0] right_operand;
  logic                is_nop;
  logic [CNT_W-1:0]    count;

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, op_code, mem_op, operand,
           left_operand, right_operand, is_nop, count
  );

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, op_code, mem_op, operand,
           left_operand, right_operand, is_nop, count
  );
endinterface

// File: rtl/id_decode_queue.sv
// Buffered decode stage: DEPTH-entry FIFO of instruction words, head split into fields.
// Chip-enable freezes everything; flush empties the queue; all-zero words optionally dropped.
module id_decode_queue #(
  parameter int INSTR_W  = 16,
  parameter int OPC_W    = 4,
  parameter int MEMOP_W  = 4,
  parameter int DEPTH    = 2,
  parameter int DROP_NOP = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               id_ce_i,
  input  logic               flush_i,
  id_decode_queue_if.slave   bus
);
  localparam int OPND_W = INSTR_W - OPC_W - MEMOP_W;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam bit DROP   = (DROP_NOP != 0);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INSTR_W-1:0] head;
  logic               push, pop, out_valid;

  // Full blocks acceptance even when a pop happens in the same cycle.
  assign bus.in_ready = id_ce_i & ~flush_i & (count_q < CNT_W'(DEPTH));
  assign push         = bus.in_valid & bus.in_ready & ~(DROP & (bus.instr == '0));
  assign out_valid    = (count_q != '0);
  assign pop          = out_valid & bus.out_ready & id_ce_i;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (id_ce_i && flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap naturally.
      if (push) begin
        mem_q[wr_ptr_q] <= bus.instr;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  assign head              = mem_q[rd_ptr_q];
  assign bus.out_valid     = out_valid;
  assign bus.count         = count_q;
  assign bus.op_code       = out_valid ? head[INSTR_W-1 -: OPC_W] : '0;
  assign bus.mem_op        = out_valid ? head[INSTR_W-OPC_W-1 -: MEMOP_W] : '0;
  assign bus.operand       = out_valid ? head[OPND_W-1:0] : '0;
  assign bus.left_operand  = out_valid ? head[OPND_W-1 -: OPND_W/2] : '0;
  assign bus.right_operand = out_valid ? head[OPND_W/2-1:0] : '0;
  assign bus.is_nop        = out_valid & (head == '0);
endmodule

// File: tb/tb_id_decode_queue.sv
// Directed bench: one DUT with NOPs kept, one with NOPs dropped, sharing clock/reset/CE/flush.
module tb_id_decode_queue;
  logic clk = 1'b0;
  logic rst, ce, flush;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  id_decode_queue_if #(.INSTR_W(16), .OPC_W(4), .MEMOP_W(4), .DEPTH(2)) bus0 ();
  id_decode_queue_if #(.INSTR_W(16), .OPC_W(4), .MEMOP_W(4), .DEPTH(2)) bus1 ();

  id_decode_queue #(.INSTR_W(16), .OPC_W(4), .MEMOP_W(4), .DEPTH(2), .DROP_NOP(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .id_ce_i(ce), .flush_i(flush), .bus(bus0)
  );
  id_decode_queue #(.INSTR_W(16), .OPC_W(4), .MEMOP_W(4), .DEPTH(2), .DROP_NOP(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .id_ce_i(ce), .flush_i(flush), .bus(bus1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; flush = 1'b0;
    bus0.in_valid = 1'b0; bus0.instr = '0; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.instr = '0; bus1.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (bus0.out_valid !== 1'b0 || bus0.count !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state: out_valid=%b count=%0d, expected 0/0", bus0.out_valid, bus0.count);
    end
    tests_run++;
    if (bus0.op_code !== 4'h0 || bus0.operand !== 8'h00 || bus0.is_nop !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_fields: op=%h operand=%h is_nop=%b, expected 0", bus0.op_code, bus0.operand, bus0.is_nop);
    end
    tests_run++;
    if (bus0.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b expected 1", bus0.in_ready);
    end
  endtask

  task automatic test_single();
    bus0.in_valid = 1'b1; bus0.instr = 16'h3A5C; bus0.out_ready = 1'b0;
    tick();
    bus0.in_valid = 1'b0;
    #1;
    tests_run++;
    if (bus0.out_valid !== 1'b1 || bus0.count !== 2'd1) begin
      tests_failed++;
      $display("FAIL single_valid: out_valid=%b count=%0d, expected 1/1", bus0.out_valid, bus0.count);
    end
    tests_run++;
    if (bus0.op_code !== 4'h3 || bus0.mem_op !== 4'hA || bus0.operand !== 8'h5C) begin
      tests_failed++;
      $display("FAIL single_fields: op=%h mem=%h operand=%h, expected 3/A/5C", bus0.op_code, bus0.mem_op, bus0.operand);
    end
    tests_run++;
    if (bus0.left_operand !== 4'h5 || bus0.right_operand !== 4'hC || bus0.is_nop !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_halves: left=%h right=%h nop=%b, expected 5/C/0", bus0.left_operand, bus0.right_operand, bus0.is_nop);
    end
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    tests_run++;
    if (bus0.count !== 2'd0 || bus0.operand !== 8'h00) begin
      tests_failed++;
      $display("FAIL single_drain: count=%0d operand=%h, expected 0/00", bus0.count, bus0.operand);
    end
  endtask

  task automatic test_full_order();
    bus0.in_valid = 1'b1; bus0.instr = 16'h1111;
    tick();
    bus0.instr = 16'h2222;
    tick();
    bus0.instr = 16'h3333;
    #1;
    tests_run++;
    if (bus0.count !== 2'd2 || bus0.in_ready !== 1'b0 || bus0.operand !== 8'h11) begin
      tests_failed++;
      $display("FAIL full_state: count=%0d in_ready=%b head=%h, expected 2/0/11", bus0.count, bus0.in_ready, bus0.operand);
    end
    bus0.out_ready = 1'b1;
    #1;
    tests_run++;
    if (bus0.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_pop_in_ready: got %b expected 0", bus0.in_ready);
    end
    tick();
    tests_run++;
    if (bus0.count !== 2'd1 || bus0.op_code !== 4'h2 || bus0.operand !== 8'h22 || bus0.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL order_second: count=%0d op=%h operand=%h in_ready=%b, expected 1/2/22/1",
               bus0.count, bus0.op_code, bus0.operand, bus0.in_ready);
    end
    tick();
    tests_run++;
    if (bus0.count !== 2'd1 || bus0.op_code !== 4'h3 || bus0.operand !== 8'h33) begin
      tests_failed++;
      $display("FAIL order_third: count=%0d op=%h operand=%h, expected 1/3/33", bus0.count, bus0.op_code, bus0.operand);
    end
    bus0.in_valid = 1'b0;
    tick();
    bus0.out_ready = 1'b0;
    tests_run++;
    if (bus0.count !== 2'd0 || bus0.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL order_drain: count=%0d out_valid=%b, expected 0/0", bus0.count, bus0.out_valid);
    end
  endtask

  task automatic test_stream();
    bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus0.instr = 16'h5000 + 16'(i * 17);
      tick();
      tests_run++;
      if (bus0.count !== 2'd1 || bus0.op_code !== 4'h5 || bus0.operand !== 8'(i * 17)) begin
        tests_failed++;
        $display("FAIL stream_%0d: count=%0d op=%h operand=%h, expected 1/5/%h",
                 i, bus0.count, bus0.op_code, bus0.operand, 8'(i * 17));
      end
    end
    bus0.in_valid = 1'b0;
    tick();
    bus0.out_ready = 1'b0;
    tests_run++;
    if (bus0.count !== 2'd0) begin
      tests_failed++;
      $display("FAIL stream_drain: count=%0d expected 0", bus0.count);
    end
  endtask

  task automatic test_ce_stall();
    bus0.in_valid = 1'b1; bus0.instr = 16'hA123;
    tick();
    bus0.instr = 16'hB456;
    tick();
    ce = 1'b0; bus0.instr = 16'hC789; bus0.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (bus0.in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_in_ready_%0d: got %b expected 0", i, bus0.in_ready);
      end
      tick();
      tests_run++;
      if (bus0.count !== 2'd2 || bus0.out_valid !== 1'b1 || bus0.op_code !== 4'hA || bus0.operand !== 8'h23) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: count=%0d valid=%b op=%h operand=%h, expected 2/1/A/23",
                 i, bus0.count, bus0.out_valid, bus0.op_code, bus0.operand);
      end
    end
    ce = 1'b1; bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    flush = 1'b1; bus0.in_valid = 1'b1; bus0.instr = 16'hD0D0; bus0.out_ready = 1'b1;
    #1;
    tests_run++;
    if (bus0.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_in_ready: got %b expected 0", bus0.in_ready);
    end
    tick();
    flush = 1'b0; bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
    #1;
    tests_run++;
    if (bus0.count !== 2'd0 || bus0.out_valid !== 1'b0 || bus0.op_code !== 4'h0 || bus0.operand !== 8'h00) begin
      tests_failed++;
      $display("FAIL flush_clear: count=%0d valid=%b op=%h operand=%h, expected 0/0/0/00",
               bus0.count, bus0.out_valid, bus0.op_code, bus0.operand);
    end
    bus0.in_valid = 1'b1; bus0.instr = 16'hE5E5;
    tick();
    bus0.in_valid = 1'b0; ce = 1'b0; flush = 1'b1;
    tick();
    tests_run++;
    if (bus0.count !== 2'd1 || bus0.operand !== 8'hE5) begin
      tests_failed++;
      $display("FAIL flush_ce_low: count=%0d operand=%h, expected 1/E5", bus0.count, bus0.operand);
    end
    ce = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++;
    if (bus0.count !== 2'd0) begin
      tests_failed++;
      $display("FAIL flush_ce_high: count=%0d expected 0", bus0.count);
    end
  endtask

  task automatic test_nop();
    bus0.in_valid = 1'b1; bus0.instr = 16'h0000;
    tick();
    bus0.in_valid = 1'b0;
    tests_run++;
    if (bus0.count !== 2'd1 || bus0.out_valid !== 1'b1 || bus0.is_nop !== 1'b1) begin
      tests_failed++;
      $display("FAIL nop_kept: count=%0d valid=%b is_nop=%b, expected 1/1/1", bus0.count, bus0.out_valid, bus0.is_nop);
    end
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;

    bus1.in_valid = 1'b1; bus1.instr = 16'h0000;
    #1;
    tests_run++;
    if (bus1.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL nop_drop_ready: got %b expected 1", bus1.in_ready);
    end
    tick();
    tests_run++;
    if (bus1.count !== 2'd0 || bus1.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL nop_dropped: count=%0d valid=%b, expected 0/0", bus1.count, bus1.out_valid);
    end
    bus1.instr = 16'h4001;
    tick();
    bus1.in_valid = 1'b0;
    tests_run++;
    if (bus1.count !== 2'd1 || bus1.op_code !== 4'h4 || bus1.operand !== 8'h01 || bus1.is_nop !== 1'b0) begin
      tests_failed++;
      $display("FAIL nop_drop_next: count=%0d op=%h operand=%h is_nop=%b, expected 1/4/01/0",
               bus1.count, bus1.op_code, bus1.operand, bus1.is_nop);
    end
  endtask

  task automatic test_reset_mid();
    bus0.in_valid = 1'b1; bus0.instr = 16'h7777;
    tick();
    bus0.instr = 16'h8888;
    tick();
    bus0.in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (bus0.count !== 2'd0 || bus0.out_valid !== 1'b0 || bus0.operand !== 8'h00 || bus1.count !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: count=%0d valid=%b operand=%h count1=%0d, expected 0/0/00/0",
               bus0.count, bus0.out_valid, bus0.operand, bus1.count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_order();
    test_stream();
    test_ce_stall();
    test_flush();
    test_nop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
